branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Execute-side counterpart of the fetch-stage branch predictor.
- Fetch pushes one record per predicted conditional branch (opcode I[13]=1, I[13:11]≠3'b100): the condition code, the predicted direction, and the alternate PC (the target not chosen).
- When execute produces flags for the oldest branch, this block compares the actual outcome with the prediction. On a mismatch it flushes all pending records and drives the corrected PC plus a flush window to fetch.
- It also keeps saturating hit/miss statistics.

Parameters:
- DEPTH, 4, number of outstanding branch records (power of 2, ≥2).
- PC_W, 11, program counter width.
- FLUSH_CYCLES, 2, cycles the flush output stays high after a mispredict (≥1).
- STAT_W, 16, width of the hit/miss counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  fetch pushes a prediction record this cycle.
- push_cond  in  2  condition code I[12:11]: 01 = JZ, 10 = JC, 11 = JNZ, 00 = always taken.
- push_taken  in  1  predicted direction, 1 = taken.
- push_alt  in  PC_W  PC to use if the prediction is wrong.
- res_valid  in  1  execute presents flags for the oldest branch.
- flag_z  in  1  zero flag.
- flag_c  in  1  carry flag.
- redirect  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  PC_W  corrected PC, valid while redirect=1.
- flush  out  1  fetch/decode must discard in-flight instructions.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- count  out  log2(DEPTH)+1  records held.
- overflow  out  1  sticky: push was attempted while full.
- underflow  out  1  sticky: res_valid was asserted while empty.
- hits  out  STAT_W  correct predictions, saturating.
- misses  out  STAT_W  mispredictions, saturating.

Behaviour:
- Reset (sync, rst=1 at a clk edge): count=0, empty=1, full=0, read/write pointers=0, redirect=0, redirect_pc=0, flush=0, overflow=0, underflow=0, hits=0, misses=0, state=RUN. Reset overrides every other input in that cycle, including mid-flush.
- Queue:
  - Circular FIFO of DEPTH entries {cond, taken, alt}. Pointers wrap modulo DEPTH.
  - count is the true occupancy, so full and empty are unambiguous.
- Outcome of the head entry:
  - actual = (cond==01)?flag_z : (cond==10)?flag_c : (cond==11)?~flag_z : 1.
  - mispredict = actual != taken.
- Resolve (res_valid=1, count>0, state=RUN):
  - Head entry is popped.
  - Correct prediction: hits increments, saturating at all-ones.
  - Mispredict:
    - On the next edge redirect=1 for exactly one cycle, with redirect_pc=head.alt.
    - misses increments, saturating.
    - The whole queue is cleared (count=0, pointers=0); younger records are wrong-path.
    - flush=1 and state=FLUSH.
  - Latency: redirect and flush appear one cycle after the res_valid edge.
- Push (push=1, state=RUN):
  - If not full, the entry is written at the write pointer.
  - If full, the entry is dropped, overflow is set, and the queue is unchanged.
  - Push and a non-mispredicting resolve in the same cycle: both take effect and count is unchanged. This is legal even when full, because the pop frees the slot in the same cycle.
  - Push and a mispredicting resolve in the same cycle: the push is discarded (wrong path), count=0, overflow is not set.
- Empty resolve: res_valid with count=0 sets underflow; no pop, no stats change, no redirect.
- FSM:
  - RUN → FLUSH on a mispredict.
  - FLUSH holds flush=1 for FLUSH_CYCLES cycles total, counted from entry, using an internal down-counter.
  - In FLUSH, push and res_valid are ignored: no overflow or underflow is set and no stats change.
  - FLUSH → RUN when the counter expires. flush=0 in the first RUN cycle, and pushes are accepted again in that cycle.
- redirect_pc holds its last value when redirect=0.

Test Plan:
- Reset, then push {01,taken=1,alt=0x123}; res_valid with flag_z=1 → no redirect; hits=1, count=0, empty=1.
- Push {10,taken=1,alt=0x055}, {11,taken=0,alt=0x200}, {01,1,0x300}; res_valid with flag_c=0 → next cycle redirect=1, redirect_pc=0x055; flush=1 for 2 cycles; count=0; misses=1; pushes during flush ignored, with overflow=0.
- Push 4 records (DEPTH=4) → full=1. 5th push alone → dropped, overflow=1. Push plus correct resolve while full → count stays 4 and the new entry becomes the tail. Pop all 4 in order; the results match the pushed order, checking pointer wrap.
- Mispredicting resolve in the same cycle as a push → count=0 afterwards; the pushed entry never resolves.
- res_valid while empty → underflow=1, hits and misses unchanged. Assert rst during FLUSH → flush=0 and all counters 0 on the next cycle.
- Preload hits to all-ones via 2^STAT_W correct resolves (use STAT_W=4) → hits stays 15 and misses is unaffected.

Source files
------------

// File: rtl/branch_resolver.sv
// Resolves fetch-stage branch predictions against execute flags, redirecting
// fetch and opening a flush window on a mispredict; keeps hit/miss statistics.
module branch_resolver #(
  parameter int DEPTH        = 4,
  parameter int PC_W         = 11,
  parameter int FLUSH_CYCLES = 2,
  parameter int STAT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [1:0]                 push_cond,
  input  logic                       push_taken,
  input  logic [PC_W-1:0]            push_alt,
  input  logic                       res_valid,
  input  logic                       flag_z,
  input  logic                       flag_c,
  output logic                       redirect,
  output logic [PC_W-1:0]            redirect_pc,
  output logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  output logic [STAT_W-1:0]          hits,
  output logic [STAT_W-1:0]          misses
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [1:0]      cond_mem  [DEPTH];
  logic            taken_mem [DEPTH];
  logic [PC_W-1:0] alt_mem   [DEPTH];

  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic [0:0]        state_reg;
  logic [FW-1:0]     flush_cnt_reg;
  logic              redirect_reg;
  logic [PC_W-1:0]   redirect_pc_reg;
  logic              overflow_reg, underflow_reg;
  logic [STAT_W-1:0] hits_reg, misses_reg;

  logic [1:0]      head_cond;
  logic            head_taken;
  logic [PC_W-1:0] head_alt;
  logic            actual;
  logic            in_run, is_full, is_empty;
  logic            resolve, mispredict, pop, accept, ovf_set, unf_set;
  logic [CW-1:0]   count_next;

  assign head_cond  = cond_mem[rd_ptr_reg];
  assign head_taken = taken_mem[rd_ptr_reg];
  assign head_alt   = alt_mem[rd_ptr_reg];

  always_comb begin
    actual = 1'b1;
    case (head_cond)
      2'b01:   actual = flag_z;
      2'b10:   actual = flag_c;
      2'b11:   actual = ~flag_z;
      default: actual = 1'b1;
    endcase
  end

  assign in_run   = (state_reg == ST_RUN);
  assign is_full  = (count_reg == CW'(DEPTH));
  assign is_empty = (count_reg == '0);

  assign resolve    = in_run && res_valid && !is_empty;
  assign mispredict = resolve && (actual != head_taken);
  assign pop        = resolve && !mispredict;
  // A pop in the same cycle frees the slot, so a push into a full queue is legal then.
  assign accept     = in_run && push && !mispredict && (!is_full || pop);
  assign ovf_set    = in_run && push && !mispredict && is_full && !pop;
  assign unf_set    = in_run && res_valid && is_empty;
  assign count_next = count_reg + CW'(accept) - CW'(pop);

  always_ff @(posedge clk) begin
    if (accept) begin
      cond_mem[wr_ptr_reg]  <= push_cond;
      taken_mem[wr_ptr_reg] <= push_taken;
      alt_mem[wr_ptr_reg]   <= push_alt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      state_reg       <= ST_RUN;
      flush_cnt_reg   <= '0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
      overflow_reg    <= 1'b0;
      underflow_reg   <= 1'b0;
      hits_reg        <= '0;
      misses_reg      <= '0;
    end else begin
      redirect_reg <= 1'b0;
      if (in_run) begin
        if (ovf_set) overflow_reg <= 1'b1;
        if (unf_set) underflow_reg <= 1'b1;
        if (mispredict) begin
          // Everything younger than the mispredicted branch is wrong-path.
          wr_ptr_reg      <= '0;
          rd_ptr_reg      <= '0;
          count_reg       <= '0;
          redirect_reg    <= 1'b1;
          redirect_pc_reg <= head_alt;
          state_reg       <= ST_FLUSH;
          flush_cnt_reg   <= FW'(FLUSH_CYCLES - 1);
          if (misses_reg != '1) misses_reg <= misses_reg + 1'b1;
        end else begin
          if (accept) wr_ptr_reg <= wr_ptr_reg + AW'(1);
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (hits_reg != '1) hits_reg <= hits_reg + 1'b1;
          end
          count_reg <= count_next;
        end
      end else begin
        if (flush_cnt_reg == '0) state_reg <= ST_RUN;
        else flush_cnt_reg <= flush_cnt_reg - FW'(1);
      end
    end
  end

  assign redirect    = redirect_reg;
  assign redirect_pc = redirect_pc_reg;
  assign flush       = (state_reg == ST_FLUSH);
  assign full        = is_full;
  assign empty       = is_empty;
  assign count       = count_reg;
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;
  assign hits        = hits_reg;
  assign misses      = misses_reg;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_branch_resolver;

  localparam int DEPTH = 4;
  localparam int PC_W = 11;
  localparam int FLUSH_CYCLES = 2;
  localparam int STAT_W = 4;
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic push = 1'b0;
  logic [1:0] push_cond = '0;
  logic push_taken = 1'b0;
  logic [PC_W-1:0] push_alt = '0;
  logic res_valid = 1'b0;
  logic flag_z = 1'b0;
  logic flag_c = 1'b0;
  logic redirect;
  logic [PC_W-1:0] redirect_pc;
  logic flush, full, empty, overflow, underflow;
  logic [$clog2(DEPTH):0] count;
  logic [STAT_W-1:0] hits, misses;

  branch_resolver #(.DEPTH(DEPTH), .PC_W(PC_W), .FLUSH_CYCLES(FLUSH_CYCLES), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .push(push), .push_cond(push_cond), .push_taken(push_taken),
    .push_alt(push_alt), .res_valid(res_valid), .flag_z(flag_z), .flag_c(flag_c),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .underflow(underflow),
    .hits(hits), .misses(misses)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      cond;
    logic            taken;
    logic [PC_W-1:0] alt;
  } rec_t;

  rec_t q[$];
  int m_hits, m_misses, m_flush_left;
  bit m_ovf, m_unf, m_red;
  logic [PC_W-1:0] m_rpc;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit outcome(input logic [1:0] cond, input logic z, input logic c);
    case (cond)
      2'b01:   return z;
      2'b10:   return c;
      2'b11:   return !z;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_hits = 0; m_misses = 0; m_flush_left = 0;
    m_ovf = 0; m_unf = 0; m_red = 0; m_rpc = '0;
  endtask

  task automatic model_update();
    rec_t h, n;
    m_red = 0;
    if (rst) begin
      model_reset();
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else begin
      bit mis = 0;
      if (res_valid) begin
        if (q.size() == 0) m_unf = 1;
        else begin
          h = q[0];
          if (outcome(h.cond, flag_z, flag_c) != h.taken) mis = 1;
          else begin
            void'(q.pop_front());
            if (m_hits < STAT_MAX) m_hits++;
          end
        end
      end
      if (mis) begin
        q.delete();
        m_red = 1;
        m_rpc = h.alt;
        m_flush_left = FLUSH_CYCLES;
        if (m_misses < STAT_MAX) m_misses++;
      end else if (push) begin
        if (q.size() < DEPTH) begin
          n.cond = push_cond; n.taken = push_taken; n.alt = push_alt;
          q.push_back(n);
        end else m_ovf = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("count", 32'(count), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("redirect", 32'(redirect), 32'(m_red));
    check("redirect_pc", 32'(redirect_pc), 32'(m_rpc));
    check("flush", 32'(flush), 32'(m_flush_left > 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
    check("hits", 32'(hits), 32'(m_hits));
    check("misses", 32'(misses), 32'(m_misses));
  endtask

  task automatic step(input logic r, input logic p, input logic [1:0] pc, input logic pt,
                      input logic [PC_W-1:0] pa, input logic rv, input logic z, input logic c);
    rst = r; push = p; push_cond = pc; push_taken = pt; push_alt = pa;
    res_valid = rv; flag_z = z; flag_c = c;
    @(posedge clk);
    #1;
    model_update();
    compare_all();
    $display("t=%0t rst=%0b push=%0b cond=%0d tk=%0b alt=%03h rv=%0b z=%0b c=%0b | cnt=%0d red=%0b pc=%03h fl=%0b ov=%0b un=%0b h=%0d m=%0d",
             $time, r, p, pc, pt, pa, rv, z, c, count, redirect, redirect_pc, flush,
             overflow, underflow, hits, misses);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 0, '0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    step(1, 0, 2'b00, 0, '0, 0, 0, 0);
    step(1, 1, 2'b01, 1, 11'h7ff, 1, 1, 1);
    check("reset_empty", 32'(empty), 32'd1);

    // correct JZ prediction
    step(0, 1, 2'b01, 1, 11'h123, 0, 0, 0);
    step(0, 0, 2'b00, 0, '0, 1, 1, 0);
    check("first_hit", 32'(hits), 32'd1);

    // JC predicted taken but carry clear: mispredict
    step(0, 1, 2'b10, 1, 11'h055, 0, 0, 0);
    step(0, 1, 2'b11, 0, 11'h200, 0, 0, 0);
    step(0, 1, 2'b01, 1, 11'h300, 0, 0, 0);
    step(0, 0, 2'b00, 0, '0, 1, 0, 0);
    check("mis_redirect", 32'(redirect), 32'd1);
    check("mis_pc", 32'(redirect_pc), 32'h055);
    step(0, 1, 2'b00, 1, 11'h111, 1, 0, 0);
    check("flush_hold", 32'(flush), 32'd1);
    check("redirect_pulse", 32'(redirect), 32'd0);
    step(0, 1, 2'b00, 1, 11'h112, 0, 0, 0);
    check("flush_done", 32'(flush), 32'd0);
    check("no_ovf_in_flush", 32'(overflow), 32'd0);

    // fill, overflow, push+pop while full, drain with wrap
    step(0, 1, 2'b00, 1, 11'h401, 0, 0, 0);
    step(0, 1, 2'b01, 1, 11'h402, 0, 0, 0);
    step(0, 1, 2'b10, 0, 11'h403, 0, 0, 0);
    step(0, 1, 2'b11, 1, 11'h404, 0, 0, 0);
    check("full_set", 32'(full), 32'd1);
    step(0, 1, 2'b00, 1, 11'h405, 0, 0, 0);
    check("overflow_set", 32'(overflow), 32'd1);
    step(0, 1, 2'b00, 1, 11'h406, 1, 0, 0);
    check("full_pushpop", 32'(count), 32'd4);
    step(0, 0, 2'b00, 0, '0, 1, 1, 0);
    step(0, 0, 2'b00, 0, '0, 1, 0, 0);
    step(0, 0, 2'b00, 0, '0, 1, 0, 0);
    step(0, 0, 2'b00, 0, '0, 1, 0, 0);
    check("drained", 32'(empty), 32'd1);

    // mispredict concurrent with push
    step(0, 1, 2'b00, 0, 11'h0aa, 0, 0, 0);
    step(0, 1, 2'b00, 1, 11'h0bb, 1, 0, 0);
    check("mis_push_count", 32'(count), 32'd0);
    idle(2);

    // empty resolve, then reset during flush
    step(0, 0, 2'b00, 0, '0, 1, 0, 0);
    check("underflow_set", 32'(underflow), 32'd1);
    step(0, 1, 2'b11, 1, 11'h0cc, 0, 0, 0);
    step(0, 0, 2'b00, 0, '0, 1, 1, 0);
    step(1, 1, 2'b00, 0, '0, 1, 0, 0);
    check("rst_in_flush", 32'(flush), 32'd0);
    check("rst_misses", 32'(misses), 32'd0);

    // saturate hits
    for (int i = 0; i < STAT_MAX + 5; i++) begin
      step(0, 1, 2'b00, 1, 11'(i), 0, 0, 0);
      step(0, 0, 2'b00, 0, '0, 1, 0, 0);
    end
    check("hits_sat", 32'(hits), 32'(STAT_MAX));
    check("misses_sat_unaffected", 32'(misses), 32'd0);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), 2'($urandom),
           1'($urandom), 11'($urandom), ($urandom_range(0, 9) < 4), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
